// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin codes shared by the coin acceptor and the vending FSM
package vend_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE   = 2'b00;
    localparam coin_t COIN_NICKEL = 2'b01;
    localparam coin_t COIN_DIME   = 2'b10;
    // Reserved; no block is allowed to drive this code.
    localparam coin_t COIN_RSVD   = 2'b11;

    // Code for a single, unambiguous event; callers screen out the both-events case.
    function automatic coin_t classify(input logic nickel_evt, input logic dime_evt);
        coin_t code;
        code = COIN_NONE;
        if (nickel_evt && !dime_evt) begin
            code = COIN_NICKEL;
        end else if (dime_evt && !nickel_evt) begin
            code = COIN_DIME;
        end
        return code;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - two-flop synchroniser, hold-time debounce and rising-edge pulse for one sensor
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic raw_in,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous sensor into the clk domain.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has held for DEBOUNCE_CYCLES samples; a bounce back restarts the count.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (sync2 == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            deb <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            deb_d <= 1'b0;
        end else begin
            deb_d <= deb;
        end
    end

    assign level = deb;
    assign rise  = deb & ~deb_d;

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced coin sensors to single-cycle coin codes with a one-entry hold buffer
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       nickel_in,
    input  logic       dime_in,
    input  logic       can,
    output logic [1:0] coin,
    output logic       reject
);

    logic  nickel_level;
    logic  nickel_evt;
    logic  dime_level;
    logic  dime_evt;

    logic  pend_valid;
    coin_t pend_code;

    logic  pend_valid_nxt;
    coin_t pend_code_nxt;
    logic  reject_nxt;

    logic  any_evt;
    logic  both_evt;
    logic  consume;
    logic  blocked;

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_nickel_deb (
        .clk        (clk),
        .sync_reset (sync_reset),
        .raw_in     (nickel_in),
        .level      (nickel_level),
        .rise       (nickel_evt)
    );

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dime_deb (
        .clk        (clk),
        .sync_reset (sync_reset),
        .raw_in     (dime_in),
        .level      (dime_level),
        .rise       (dime_evt)
    );

    assign any_evt  = nickel_evt | dime_evt;
    assign both_evt = nickel_evt & dime_evt;
    // The FSM ignores coin while can is high, so the buffer only drains with can low.
    assign consume  = pend_valid & ~can;
    assign blocked  = pend_valid & can;

    assign coin = consume ? pend_code : COIN_NONE;

    // Classify events and decide buffer load/drain and return-chute pulses.
    always_comb begin
        pend_valid_nxt = pend_valid;
        pend_code_nxt  = pend_code;
        reject_nxt     = 1'b0;

        if (consume) begin
            pend_valid_nxt = 1'b0;
        end

        if (both_evt) begin
            reject_nxt = 1'b1;
        end else if (any_evt) begin
            if (blocked) begin
                // Buffer is full and not draining: keep the held coin, return the new one.
                reject_nxt = 1'b1;
            end else begin
                pend_valid_nxt = 1'b1;
                pend_code_nxt  = classify(nickel_evt, dime_evt);
            end
        end
    end

    // Buffer and reject registers; reset drops a pending coin without rejecting it.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pend_valid <= 1'b0;
            pend_code  <= COIN_NONE;
            reject     <= 1'b0;
        end else begin
            pend_valid <= pend_valid_nxt;
            pend_code  <= pend_code_nxt;
            reject     <= reject_nxt;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - scoreboard bench for coin_acceptor
module tb_coin_acceptor;

    localparam int D   = 4;
    localparam int LAT = D + 3;

    logic       clk;
    logic       sync_reset;
    logic       nickel_in;
    logic       dime_in;
    logic       can;
    logic [1:0] coin;
    logic       reject;

    typedef struct {
        int         cyc;
        logic [1:0] coin;
        logic       rej;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_tests;
    int   n_fail;
    logic mon_en;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .nickel_in  (nickel_in),
        .dime_in    (dime_in),
        .can        (can),
        .coin       (coin),
        .reject     (reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after posedge N settles, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int c, input logic [1:0] cv, input logic r);
        exp_t e;
        e.cyc  = c;
        e.coin = cv;
        e.rej  = r;
        sb.push_back(e);
    endtask

    // Every non-idle output cycle must match the next scoreboard entry.
    always @(negedge clk) begin
        if (mon_en && (coin !== 2'b00 || reject !== 1'b0)) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {29'd0, coin, reject}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_cyc",  cyc,    e.cyc);
                check("out_coin", coin,   e.coin);
                check("out_rej",  reject, e.rej);
            end
        end
    end

    task automatic drained(input string tag);
        check(tag, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int k;
        cyc        = 0;
        n_tests    = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        sync_reset = 1'b1;
        nickel_in  = 1'b0;
        dime_in    = 1'b0;
        can        = 1'b0;
        tick(2);
        sync_reset = 1'b0;
        check("rst_coin",   coin,   2'b00);
        check("rst_reject", reject, 1'b0);
        tick(2);
        mon_en = 1'b1;

        // 1: single nickel
        k = cyc;
        nickel_in = 1'b1;
        expect_out(k + LAT, 2'b01, 1'b0);
        tick(12);
        nickel_in = 1'b0;
        tick(12);
        drained("t1_drained");

        // 2: dime glitch shorter than debounce window
        dime_in = 1'b1;
        tick(3);
        dime_in = 1'b0;
        tick(20);
        drained("t2_drained");

        // 3: both sensors together -> reject only
        k = cyc;
        nickel_in = 1'b1;
        dime_in   = 1'b1;
        expect_out(k + LAT, 2'b00, 1'b1);
        tick(12);
        nickel_in = 1'b0;
        dime_in   = 1'b0;
        tick(12);
        drained("t3_drained");

        // 4: can high on edges 7-8 holds the nickel
        k = cyc;
        nickel_in = 1'b1;
        expect_out(k + LAT + 1, 2'b01, 1'b0);
        tick(LAT - 1);
        can = 1'b1;
        tick(2);
        can = 1'b0;
        tick(6);
        nickel_in = 1'b0;
        tick(12);
        drained("t4_drained");

        // 5: dime held by can, nickel arrives -> nickel rejected, dime delivered once
        k = cyc;
        dime_in = 1'b1;
        can     = 1'b1;
        expect_out(k + 3 + LAT, 2'b00, 1'b1);
        expect_out(k + 14,      2'b10, 1'b0);
        tick(3);
        nickel_in = 1'b1;
        tick(11);
        can = 1'b0;
        tick(1);
        nickel_in = 1'b0;
        dime_in   = 1'b0;
        tick(14);
        drained("t5_drained");

        // 6: reset mid-debounce with nickel held high
        k = cyc;
        nickel_in = 1'b1;
        tick(4);
        sync_reset = 1'b1;
        tick(1);
        check("t6_rst_coin",   coin,   2'b00);
        check("t6_rst_reject", reject, 1'b0);
        sync_reset = 1'b0;
        expect_out(cyc + LAT, 2'b01, 1'b0);
        tick(14);
        nickel_in = 1'b0;
        tick(12);
        drained("t6_drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage directly upstream of the vending machine FSM. Takes raw, asynchronous, bouncy nickel and dime sensor levels, synchronises and debounces them, and converts each debounced rising edge into a single-cycle coin code. It holds a coin in a one-entry buffer while the downstream `can` is high, because the FSM ignores `coin` in its dispense cycle. Coins that cannot be accepted are flagged on `reject`, which drives the return-chute gate.

## Interface
- `DEBOUNCE_CYCLES`, default 4, is the number of consecutive synchronised samples a new level must hold before it is accepted. The legal range is 2..255. The counter width is `$clog2(DEBOUNCE_CYCLES)`.
- `clk`: input, 1 bit, the system clock.
- `sync_reset`: input, 1 bit, reset. One clock; reset is synchronous and active-high.
- `nickel_in`: input, 1 bit, raw nickel sensor. It is asynchronous and bouncy.
- `dime_in`: input, 1 bit, raw dime sensor. It is asynchronous and bouncy.
- `can`: input, 1 bit, the dispense indication fed back from the vending machine FSM.
- `coin`: output, 2 bits, the coin code to the FSM: 00 none, 01 nickel, 10 dime. The code 11 is never driven.
- `reject`: output, 1 bit, a one-cycle registered pulse meaning a coin was returned.

## Operation
- **Synchroniser:** each sensor passes through 2 flops, reset to 0.
- **Debounce, per channel:**
  - Registers: `deb` (debounced level) and `cnt`, both reset to 0.
  - On each edge where `sync2 == deb`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, then `deb <= sync2` and `cnt <= 0`.
  - Otherwise, `cnt <= cnt+1`.
  - A level that returns before the count completes is discarded.
- **Edge detect:**
  - `deb_d` is a registered copy of `deb`.
  - `evt = deb & ~deb_d` is combinational and lasts one cycle.
  - Falling edges produce nothing.
- **Event classification:**
  - Nickel event only: code 01.
  - Dime event only: code 10.
  - Both events in the same cycle: ambiguous. `reject` is pulsed next cycle and no code is buffered.
- **Pending buffer:** registers `pend_valid` and `pend_code`.
  - `coin = (pend_valid && !can) ? pend_code : 2'b00`. This is a combinational gate on `can` only.
  - Consume: when `pend_valid && !can`, `pend_valid` clears at the next edge.
  - Load: a classified event sets `pend_valid` and `pend_code` at the next edge.
  - Simultaneous consume and load: the new code loads, and `pend_valid` stays 1.
  - Event while `pend_valid && can` (buffer full, not draining): the new coin is dropped and `reject` pulses next cycle. The buffered coin is kept.
- **Reset:**
  - `sync_reset` clears all flops in the same edge, including mid-debounce and a pending coin. A pending coin is lost and not rejected.
  - A sensor held high across reset debounces from scratch and yields one coin after release.

## Timing
- **Reset values:** `coin = 00` and `reject = 0` in the cycle after the `sync_reset` edge. All internal state is 0.
- **Latency:** take edge 1 as the first edge sampling a raw high that stays stable.
  - `deb` rises at edge `DEBOUNCE_CYCLES+2`.
  - `pend_valid` sets at edge `DEBOUNCE_CYCLES+3`.
  - `coin` is valid from that edge for exactly one cycle if `can = 0`.
  - With the default of 4, the coin appears after edge 7.
- **`reject`:** asserted in the same cycle in which a normal load would have made `pend_valid` visible. Width is exactly one cycle.
- **`can` high:** `coin` is forced to 00 while `can` is high. The held code appears in the first cycle with `can = 0`.
- **Same-channel events:** two events on one channel are at least `2*DEBOUNCE_CYCLES` cycles apart. Only cross-channel coins can collide with the buffer.
- **Throughput:** one coin per cycle at most.
- **Combinational path:** the only one is `can` to `coin`. There is no path from `coin` to `can` inside this block.

## Structure
- **Shared package `vend_pkg`:**
  - `COIN_NONE` = 2'b00, `COIN_NICKEL` = 2'b01, `COIN_DIME` = 2'b10.
  - `COIN_RSVD` = 2'b11 is reserved and never driven.
  - Holding these in the package keeps the FSM's coin codes in one place.
- **Sub-module `coin_debounce`:**
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports `clk`, `sync_reset`, `raw_in`, `level`, `rise`.
  - Contains the synchroniser, counter and edge detect, and is instantiated once per sensor.
- **Top level:** holds classification, the pending buffer and the reject flop.

## Test plan
1. `nickel_in` high for 12 cycles, `can = 0`, D = 4: `coin = 01` for exactly one cycle after edge 7. `reject` stays 0.
2. `dime_in` glitch high for 3 cycles, then low, D = 4: `coin` stays 00 and `reject` stays 0 for 20 cycles.
3. Both sensors rise on the same edge: `reject = 1` for one cycle after edge 7. `coin` stays 00 throughout.
4. Nickel event, with `can` forced 1 on edges 7–8: `coin = 00` while `can = 1`, then `coin = 01` in the first cycle with `can = 0`. It appears once only.
5. Dime held pending (`can = 1`) when a nickel event arrives: `reject` pulses one cycle. After `can` falls, `coin = 10` appears once and no 01 follows.
6. `sync_reset` at `cnt = 2` with `nickel_in` held high: outputs are 00/0 the next cycle. After release, the coin appears after edge 7 relative to release, exactly once.
